dcmi_bus_arbiter: RTL and testbench

- Shares the single DCMI master bus (DATA/DSYNC/DCLK) between up to N frame sources, e.g. the test-frame generator and the SPI-fed TX buffer.
- Replaces the wired-OR of source outputs with round-robin, frame-atomic granting.
- Enforces a minimum idle gap between frames and a watchdog on stuck requesters.
- All bus decisions are aligned to the shared DCMI clock-enable tick.

---
 rtl/dcmi_bus_arbiter_if.sv | 29 ++
 rtl/dcmi_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dcmi_bus_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcmi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dcmi_bus_arbiter_if
// Description : Requester-side and shared DCMI bus signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcmi_bus_arbiter_if #(
    parameter int N = 4
) ();
    logic [N-1:0]   REQ;
    logic [8*N-1:0] DI;
    logic [N-1:0]   DSI;
    logic [N-1:0]   GNT;
    logic [7:0]     DATA;
    logic           DSYNC;
    logic           BUSY;
    logic           ABORT;

    modport master (
        output REQ, DI, DSI,
        input  GNT, DATA, DSYNC, BUSY, ABORT
    );

    modport slave (
        input  REQ, DI, DSI,
        output GNT, DATA, DSYNC, BUSY, ABORT
    );
endinterface
`default_nettype wire

// File: rtl/dcmi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dcmi_bus_arbiter
// Description : Round-robin, frame-atomic DCMI bus sharing with idle gap
//               and stuck-requester watchdog, stepped on the CLKEN tick.
// Revision    : 1.0 - initial release
// ============================================================================
module dcmi_bus_arbiter #(
    parameter int N             = 4,
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  wire               CLK,
    input  wire               nRST,
    input  wire               CLKEN,
    dcmi_bus_arbiter_if.slave bus
);
    localparam int c_PW = (N > 1) ? $clog2(N) : 1;
    localparam int c_GW = $clog2(GAP_TICKS + 1);
    localparam int c_TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    localparam logic [c_PW-1:0] c_LAST    = c_PW'(N - 1);
    localparam logic [c_GW-1:0] c_GAP_END = c_GW'(GAP_TICKS);
    localparam logic [c_TW-1:0] c_TIMEOUT = c_TW'(TIMEOUT_TICKS);
    localparam logic [N-1:0]    c_ONE     = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N-1:0]      r_gnt, w_gnt_nxt;
    logic [c_PW-1:0]   r_gidx, w_gidx_nxt;
    logic [c_PW-1:0]   r_ptr, w_ptr_nxt;
    logic [N-1:0]      r_lock, w_lock_nxt;
    logic [c_TW-1:0]   r_tick, w_tick_nxt, w_tick_inc;
    logic [c_GW-1:0]   r_gap, w_gap_nxt, w_gap_inc;
    logic [7:0]        r_data, w_data_nxt;
    logic              r_dsync, w_dsync_nxt;
    logic              r_abort, w_abort_nxt;

    logic [N-1:0]      w_elig;
    logic [c_PW-1:0]   w_pick;
    logic              w_found;
    logic [c_PW-1:0]   w_ptr_rel;
    int                v_idx;

    assign w_elig     = bus.REQ & ~r_lock;
    assign w_tick_inc = (r_tick == '1) ? r_tick : r_tick + 1'b1;
    assign w_gap_inc  = (r_gap  == '1) ? r_gap  : r_gap  + 1'b1;
    assign w_ptr_rel  = (r_gidx == c_LAST) ? '0 : r_gidx + 1'b1;

    // First eligible requester at or above the pointer, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = 0;
        for (int k = 0; k < N; k++) begin
            v_idx = (int'(r_ptr) + k) % N;
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_pick  = c_PW'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        w_tick_nxt  = r_tick;
        w_gap_nxt   = r_gap;
        w_abort_nxt = 1'b0;
        if (CLKEN) begin
            w_lock_nxt = r_lock & bus.REQ;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        w_state_nxt = S_GRANT;
                        w_gnt_nxt   = c_ONE << w_pick;
                        w_gidx_nxt  = w_pick;
                        w_tick_nxt  = '0;
                    end
                end
                S_GRANT: begin
                    w_tick_nxt = w_tick_inc;
                    // A release on the expiry tick wins over the watchdog.
                    if (!bus.REQ[r_gidx]) begin
                        w_state_nxt = S_GAP;
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = w_ptr_rel;
                        w_gap_nxt   = '0;
                    end else if ((TIMEOUT_TICKS != 0) && (w_tick_inc == c_TIMEOUT)) begin
                        w_state_nxt        = S_GAP;
                        w_gnt_nxt          = '0;
                        w_ptr_nxt          = w_ptr_rel;
                        w_gap_nxt          = '0;
                        w_abort_nxt        = 1'b1;
                        w_lock_nxt[r_gidx] = 1'b1;
                    end
                end
                S_GAP: begin
                    w_gap_nxt = w_gap_inc;
                    if (w_gap_inc == c_GAP_END) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Bus mux follows the current grant, giving one CLK of latency.
    always_comb begin
        w_data_nxt  = 8'h00;
        w_dsync_nxt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt[i]) begin
                w_data_nxt  = w_data_nxt | bus.DI[8*i +: 8];
                w_dsync_nxt = w_dsync_nxt | bus.DSI[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_lock  <= '0;
            r_tick  <= '0;
            r_gap   <= '0;
            r_data  <= 8'h00;
            r_dsync <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
            r_tick  <= w_tick_nxt;
            r_gap   <= w_gap_nxt;
            r_data  <= w_data_nxt;
            r_dsync <= w_dsync_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign bus.GNT   = r_gnt;
    assign bus.DATA  = r_data;
    assign bus.DSYNC = r_dsync;
    assign bus.BUSY  = (r_state != S_IDLE);
    assign bus.ABORT = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_dcmi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcmi_bus_arbiter
// Description : Self-checking bench for dcmi_bus_arbiter (N=4, gap 4, tmo 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcmi_bus_arbiter;
    localparam int c_N   = 4;
    localparam int c_GAP = 4;
    localparam int c_TMO = 16;

    logic       CLK   = 1'b0;
    logic       nRST  = 1'b0;
    logic       CLKEN = 1'b0;
    logic [1:0] r_div = 2'd0;

    int tests_run    = 0;
    int tests_failed = 0;
    int sb[$];
    int exp_idx;

    dcmi_bus_arbiter_if #(.N(c_N)) bus ();

    dcmi_bus_arbiter #(
        .N             (c_N),
        .GAP_TICKS     (c_GAP),
        .TIMEOUT_TICKS (c_TMO)
    ) u_dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .CLKEN (CLKEN),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // CLKEN high on one CLK out of every four.
    always @(posedge CLK) begin
        r_div <= r_div + 2'd1;
        CLKEN <= (r_div == 2'd3);
    end

    task automatic next_tick();
        do @(posedge CLK); while (CLKEN !== 1'b1);
        #1;
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        bus.REQ = '0;
        bus.DI  = '0;
        bus.DSI = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST    = 1'b0;
        bus.REQ = '0;
        bus.DI  = '0;
        bus.DSI = '0;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if (bus.GNT !== 4'b0 || bus.DATA !== 8'h00 || bus.DSYNC !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.ABORT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: GNT=%b DATA=%h DSYNC=%b BUSY=%b ABORT=%b, required all zero",
                     bus.GNT, bus.DATA, bus.DSYNC, bus.BUSY, bus.ABORT);
        end
        @(negedge CLK);
        nRST = 1'b1;
        next_tick();
        tests_run++;
        if (bus.BUSY !== 1'b0 || bus.GNT !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_noreq: BUSY=%b GNT=%b, required 0 and 0000", bus.BUSY, bus.GNT);
        end
    endtask

    task automatic test_single();
        do_reset();
        next_tick();
        bus.REQ[2] = 1'b1;
        sb.push_back(2);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL single_grant: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        bus.DI[23:16] = 8'h5A;
        bus.DSI[2]    = 1'b1;
        tests_run++;
        if (bus.DATA !== 8'h00) begin
            tests_failed++;
            $display("FAIL single_no_early: DATA=%h required 00", bus.DATA);
        end
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.DATA !== 8'h5A || bus.DSYNC !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: DATA=%h DSYNC=%b required 5a 1", bus.DATA, bus.DSYNC);
        end
        repeat (2) next_tick();
        bus.REQ[2]    = 1'b0;
        bus.DI[23:16] = 8'h00;
        bus.DSI[2]    = 1'b0;
        next_tick();
        tests_run++;
        if (bus.GNT !== 4'b0 || bus.BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_release: GNT=%b BUSY=%b required 0000 1", bus.GNT, bus.BUSY);
        end
        for (int k = 1; k <= c_GAP; k++) begin
            next_tick();
            tests_run++;
            if (bus.BUSY !== (k < c_GAP) || bus.DSYNC !== 1'b0 || bus.GNT !== 4'b0) begin
                tests_failed++;
                $display("FAIL single_gap tick %0d: BUSY=%b DSYNC=%b GNT=%b required %b 0 0000",
                         k, bus.BUSY, bus.DSYNC, bus.GNT, (k < c_GAP));
            end
        end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        next_tick();
        bus.REQ = 4'b1011;
        sb.push_back(0); sb.push_back(1); sb.push_back(3); sb.push_back(0);
        next_tick();
        for (int f = 0; f < 4; f++) begin
            exp_idx = sb.pop_front();
            tests_run++;
            if (bus.GNT !== (4'b0001 << exp_idx)) begin
                tests_failed++;
                $display("FAIL rr_grant frame %0d: GNT=%b required %b", f, bus.GNT, 4'b0001 << exp_idx);
            end
            g = exp_idx;
            bus.DSI[g]       = 1'b1;
            bus.DI[8*g +: 8] = 8'h10 + 8'(f);
            repeat (9) next_tick();
            tests_run++;
            if (bus.DSYNC !== 1'b1 || bus.DATA !== 8'h10 + 8'(f)) begin
                tests_failed++;
                $display("FAIL rr_frame_data frame %0d: DATA=%h DSYNC=%b required %h 1",
                         f, bus.DATA, bus.DSYNC, 8'h10 + 8'(f));
            end
            bus.REQ[g]       = 1'b0;
            bus.DSI[g]       = 1'b0;
            bus.DI[8*g +: 8] = 8'h00;
            next_tick();
            bus.REQ[g] = 1'b1;
            for (int k = 1; k <= c_GAP; k++) begin
                next_tick();
                tests_run++;
                if (bus.GNT !== 4'b0 || bus.DSYNC !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_gap frame %0d tick %0d: GNT=%b DSYNC=%b required 0000 0",
                             f, k, bus.GNT, bus.DSYNC);
                end
            end
            if (f < 3) next_tick();
        end
    endtask

    task automatic test_isolation();
        do_reset();
        bus.DI[7:0] = 8'hFF;
        bus.DSI[0]  = 1'b1;
        next_tick();
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.DATA !== 8'h00 || bus.DSYNC !== 1'b0) begin
            tests_failed++;
            $display("FAIL iso_idle: DATA=%h DSYNC=%b required 00 0", bus.DATA, bus.DSYNC);
        end
        bus.REQ[1] = 1'b1;
        sb.push_back(1);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL iso_grant: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        bus.DI[15:8] = 8'h3C;
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.DATA !== 8'h3C || bus.DSYNC !== 1'b0) begin
            tests_failed++;
            $display("FAIL iso_track1: DATA=%h DSYNC=%b required 3c 0", bus.DATA, bus.DSYNC);
        end
        bus.DI[15:8] = 8'hC3;
        bus.DSI[1]   = 1'b1;
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.DATA !== 8'hC3 || bus.DSYNC !== 1'b1) begin
            tests_failed++;
            $display("FAIL iso_track2: DATA=%h DSYNC=%b required c3 1", bus.DATA, bus.DSYNC);
        end
        next_tick();
        bus.REQ[1]   = 1'b0;
        bus.DI[15:8] = 8'h00;
        bus.DSI[1]   = 1'b0;
        next_tick();
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.DATA !== 8'h00 || bus.DSYNC !== 1'b0) begin
            tests_failed++;
            $display("FAIL iso_nogrant: DATA=%h DSYNC=%b required 00 0", bus.DATA, bus.DSYNC);
        end
        bus.DI[7:0] = 8'h00;
        bus.DSI[0]  = 1'b0;
    endtask

    task automatic test_watchdog();
        int bad = 0;
        do_reset();
        next_tick();
        bus.REQ[3] = 1'b1;
        sb.push_back(3);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL wd_grant: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        for (int t = 1; t < c_TMO; t++) begin
            next_tick();
            if (bus.ABORT !== 1'b0 || bus.GNT !== 4'b1000) bad++;
            if (t == 5) bus.REQ[0] = 1'b1;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL wd_hold: %0d early ticks with ABORT/GNT wrong, required 0", bad);
        end
        next_tick();
        tests_run++;
        if (bus.ABORT !== 1'b1 || bus.GNT !== 4'b0 || bus.BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_abort: ABORT=%b GNT=%b BUSY=%b required 1 0000 1",
                     bus.ABORT, bus.GNT, bus.BUSY);
        end
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.ABORT !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_pulse_width: ABORT=%b required 0", bus.ABORT);
        end
        sb.push_back(0);
        repeat (c_GAP) next_tick();
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL wd_after_gap: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        repeat (2) next_tick();
        bus.REQ[0] = 1'b0;
        next_tick();
        repeat (c_GAP + 3) next_tick();
        tests_run++;
        if (bus.GNT !== 4'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_lockout: GNT=%b BUSY=%b required 0000 0", bus.GNT, bus.BUSY);
        end
        bus.REQ[3] = 1'b0;
        next_tick();
        bus.REQ[3] = 1'b1;
        sb.push_back(3);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL wd_regrant: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        bus.REQ[3] = 1'b0;
        next_tick();
    endtask

    task automatic test_collision();
        do_reset();
        next_tick();
        bus.REQ[1] = 1'b1;
        sb.push_back(1);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL col_grant: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        repeat (c_TMO - 1) next_tick();
        bus.REQ[1] = 1'b0;
        next_tick();
        tests_run++;
        if (bus.ABORT !== 1'b0 || bus.GNT !== 4'b0 || bus.BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL col_no_abort: ABORT=%b GNT=%b BUSY=%b required 0 0000 1",
                     bus.ABORT, bus.GNT, bus.BUSY);
        end
        bus.REQ[1] = 1'b1;
        sb.push_back(1);
        repeat (c_GAP) next_tick();
        tests_run++;
        if (bus.GNT !== 4'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL col_gap: GNT=%b BUSY=%b required 0000 0", bus.GNT, bus.BUSY);
        end
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL col_regrant: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        bus.REQ[1] = 1'b0;
        next_tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        next_tick();
        bus.REQ[2] = 1'b1;
        sb.push_back(2);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL ar_grant2: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        bus.REQ[2] = 1'b0;
        next_tick();
        repeat (c_GAP) next_tick();
        bus.REQ = 4'b1010;
        sb.push_back(3);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL ar_grant3: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        bus.DI[31:24] = 8'hAA;
        bus.DSI[3]    = 1'b1;
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.DATA !== 8'hAA || bus.DSYNC !== 1'b1) begin
            tests_failed++;
            $display("FAIL ar_data: DATA=%h DSYNC=%b required aa 1", bus.DATA, bus.DSYNC);
        end
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        tests_run++;
        if (bus.GNT !== 4'b0 || bus.DATA !== 8'h00 || bus.DSYNC !== 1'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL ar_immediate: GNT=%b DATA=%h DSYNC=%b BUSY=%b required all zero",
                     bus.GNT, bus.DATA, bus.DSYNC, bus.BUSY);
        end
        bus.DI[31:24] = 8'h00;
        bus.DSI[3]    = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        sb.push_back(1);
        next_tick();
        exp_idx = sb.pop_front();
        tests_run++;
        if (bus.GNT !== (4'b0001 << exp_idx)) begin
            tests_failed++;
            $display("FAIL ar_first_after_reset: GNT=%b required %b", bus.GNT, 4'b0001 << exp_idx);
        end
        do_reset();
    endtask

    initial begin
        bus.REQ = '0;
        bus.DI  = '0;
        bus.DSI = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_isolation();
        test_watchdog();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
